// File: rtl/matmul_pkg.sv
// Shared types and helpers for the small-K matmul operand feeder.
package matmul_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    LOAD_A = 3'd2,
    STREAM = 3'd3,
    FINISH = 3'd4
  } feeder_state_e;

  // Counter width for a 0..depth-1 range, never narrower than one bit.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matmul_small_k_operand_feeder_if.sv
// Operand fetch (A/B) and core-facing pair stream of the small-K feeder.
interface matmul_small_k_operand_feeder_if
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              b_valid;
  logic              b_ready;
  logic [DATA_W-1:0] b_data;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] a_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_last_k;
  logic              out_last;

  modport master (
    input  b_valid, b_data, a_valid, a_data, out_ready,
    output b_ready, a_ready, out_valid, out_a, out_b, out_last_k, out_last
  );

  modport slave (
    output b_valid, b_data, a_valid, a_data, out_ready,
    input  b_ready, a_ready, out_valid, out_a, out_b, out_last_k, out_last
  );
endinterface

// File: rtl/operand_regfile.sv
// DEPTH x DATA_W operand buffer: synchronous write, combinational read.
module operand_regfile
  import matmul_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  localparam int AW    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; every word is written before use.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/matmul_small_k_operand_feeder.sv
// Holds a resident K x N B tile plus one A row and streams (a, b) pairs
// to the matmul core in dot-product order, one pair per cycle.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// LOAD_B | accepting K*N B words, row-major
// LOAD_A | accepting K words of the current A row
// STREAM | presenting pairs, n outer / k inner
// FINISH | done pulse, back to IDLE
module matmul_small_k_operand_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 4,
  parameter int N      = 8,
  parameter int ROWS_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [ROWS_W-1:0]     cfg_rows,
  matmul_small_k_operand_feeder_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = cnt_w(K * N);
  localparam int K_W   = cnt_w(K);
  localparam int N_W   = cnt_w(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K * N - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(K - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(N - 1);

  feeder_state_e state, state_nxt;

  logic [ROWS_W-1:0] m_rows, row;
  logic [IDX_W-1:0]  idx, rd_idx;
  logic [K_W-1:0]    k_cnt, rd_k;
  logic [N_W-1:0]    n_cnt, rd_n;
  logic              b_fire, a_fire, out_fire;
  logic              k_last, n_last, row_last;
  logic              pair_last_k, pair_last;
  logic [DATA_W-1:0] a_rd, b_rd, a_pair;

  assign b_fire   = (state == LOAD_B) && bus.b_valid;
  assign a_fire   = (state == LOAD_A) && bus.a_valid;
  assign out_fire = (state == STREAM) && bus.out_valid && bus.out_ready;

  assign bus.b_ready = (state == LOAD_B);
  assign bus.a_ready = (state == LOAD_A);
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);

  assign k_last   = (k_cnt == K_LAST);
  assign n_last   = (n_cnt == N_LAST);
  assign row_last = (row == m_rows - ROWS_W'(1));

  // Address of the pair to be loaded into the output registers next:
  // (0,0) when entering STREAM, otherwise the successor of (k_cnt, n_cnt).
  always_comb begin
    rd_k = '0;
    rd_n = '0;
    if (state == STREAM) begin
      rd_k = k_last ? '0 : k_cnt + K_W'(1);
      rd_n = !k_last ? n_cnt : (n_last ? '0 : n_cnt + N_W'(1));
    end
    rd_idx = IDX_W'(32'(rd_k) * N + 32'(rd_n));
  end

  assign pair_last_k = (rd_k == K_LAST);
  assign pair_last   = pair_last_k && (rd_n == N_LAST) && row_last;
  // With K == 1 the only A word is being written on the same edge it is needed.
  assign a_pair = ((K == 1) && (state == LOAD_A)) ? bus.a_data : a_rd;

  operand_regfile #(.DEPTH(K * N), .DATA_W(DATA_W)) u_b_buf (
    .clk   (clk),
    .we    (b_fire),
    .waddr (idx),
    .wdata (bus.b_data),
    .raddr (rd_idx),
    .rdata (b_rd)
  );

  operand_regfile #(.DEPTH(K), .DATA_W(DATA_W)) u_a_buf (
    .clk   (clk),
    .we    (a_fire),
    .waddr (k_cnt),
    .wdata (bus.a_data),
    .raddr (rd_k),
    .rdata (a_rd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cfg_start) state_nxt = (cfg_rows == '0) ? FINISH : LOAD_B;
      LOAD_B: if (b_fire && (idx == IDX_LAST)) state_nxt = LOAD_A;
      LOAD_A: if (a_fire && k_last) state_nxt = STREAM;
      STREAM: if (out_fire && k_last && n_last) state_nxt = row_last ? FINISH : LOAD_A;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rows         <= '0;
      row            <= '0;
      idx            <= '0;
      k_cnt          <= '0;
      n_cnt          <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_a      <= '0;
      bus.out_b      <= '0;
      bus.out_last_k <= 1'b0;
      bus.out_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            m_rows <= cfg_rows;
            row    <= '0;
            idx    <= '0;
            k_cnt  <= '0;
            n_cnt  <= '0;
          end
        end
        LOAD_B: begin
          if (b_fire) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        LOAD_A: begin
          if (a_fire) begin
            if (k_last) begin
              k_cnt          <= '0;
              n_cnt          <= '0;
              bus.out_valid  <= 1'b1;
              bus.out_a      <= a_pair;
              bus.out_b      <= b_rd;
              bus.out_last_k <= pair_last_k;
              bus.out_last   <= pair_last;
            end else begin
              k_cnt <= k_cnt + K_W'(1);
            end
          end
        end
        STREAM: begin
          if (out_fire) begin
            if (k_last && n_last) begin
              bus.out_valid  <= 1'b0;
              bus.out_last_k <= 1'b0;
              bus.out_last   <= 1'b0;
              k_cnt          <= '0;
              n_cnt          <= '0;
              if (!row_last) row <= row + ROWS_W'(1);
            end else begin
              k_cnt          <= rd_k;
              n_cnt          <= rd_n;
              bus.out_a      <= a_pair;
              bus.out_b      <= b_rd;
              bus.out_last_k <= pair_last_k;
              bus.out_last   <= pair_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_small_k_operand_feeder.sv
// Directed bench for the small-K operand feeder: B[i] = i, A row r = {10,20,30,40} + 100*r.
module tb_matmul_small_k_operand_feeder;

  localparam int K  = 4;
  localparam int N  = 8;
  localparam int KN = K * N;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_rows = '0;
  logic        busy, done;
  int          total_chk = 0;
  int          bad_chk = 0;

  matmul_small_k_operand_feeder_if #(.DATA_W(32)) bus ();

  matmul_small_k_operand_feeder #(.DATA_W(32), .K(K), .N(N), .ROWS_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_rows  (cfg_rows),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_chk++;
    if (obs !== exp) begin
      bad_chk++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int a_val(input int r, input int k);
    return 10 * (k + 1) + 100 * r;
  endfunction

  task automatic send_b(input int d, input int gap);
    int w;
    bus.b_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.b_valid = 1'b1;
    bus.b_data  = 32'(d);
    w = 0;
    while (!bus.b_ready && w < BUDGET) begin @(negedge clk); w++; end
    if (w >= BUDGET) chk("b_timeout", 32'(w), 32'(0));
    @(negedge clk);
    bus.b_valid = 1'b0;
  endtask

  task automatic send_a(input int d, input int gap);
    int w;
    bus.a_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.a_valid = 1'b1;
    bus.a_data  = 32'(d);
    w = 0;
    while (!bus.a_ready && w < BUDGET) begin @(negedge clk); w++; end
    if (w >= BUDGET) chk("a_timeout", 32'(w), 32'(0));
    @(negedge clk);
    bus.a_valid = 1'b0;
  endtask

  task automatic feed(input int m, input bit gaps);
    for (int i = 0; i < KN; i++) send_b(i, gaps ? int'($urandom_range(0, 3)) : 0);
    chk("b_ready_off", 32'(bus.b_ready), 32'(0));
    for (int r = 0; r < m; r++) begin
      for (int k = 0; k < K; k++) send_a(a_val(r, k), gaps ? int'($urandom_range(0, 3)) : 0);
      // first pair is registered on the edge that accepted A word K-1
      chk("first_valid", 32'(bus.out_valid), 32'(1));
    end
  endtask

  task automatic consume(input int total, input bit bp, input int abort_at, input int poke_at);
    int p, cyc, lasts, r, q, n, k;
    bit poked, aborted;
    p = 0; cyc = 0; lasts = 0; poked = 0; aborted = 0;
    while (p < total && cyc < BUDGET && !aborted) begin
      @(negedge clk);
      cyc++;
      cfg_start = 1'b0;
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("busy", 32'(busy), 32'(1));
      chk("rdy_excl", 32'(bus.a_ready & bus.b_ready), 32'(0));
      if (bus.out_valid) begin
        r = p / KN; q = p % KN; n = q / K; k = q % K;
        chk("rdy_stream", 32'(bus.a_ready | bus.b_ready), 32'(0));
        chk("out_a", bus.out_a, 32'(a_val(r, k)));
        chk("out_b", bus.out_b, 32'(k * N + n));
        chk("last_k", 32'(bus.out_last_k), 32'(k == K - 1));
        chk("last", 32'(bus.out_last), 32'(p == total - 1));
        if (p == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_valid", 32'(bus.out_valid), 32'(0));
          chk("rst_busy", 32'(busy), 32'(0));
          chk("rst_done", 32'(done), 32'(0));
          aborted = 1;
        end else begin
          if (p == poke_at && !poked) begin
            cfg_rows  = 16'd7;
            cfg_start = 1'b1;
            poked     = 1;
          end
          if (bus.out_ready) begin
            if (bus.out_last) lasts++;
            p++;
          end
        end
      end
    end
    if (!aborted) begin
      if (cyc >= BUDGET) chk("stream_timeout", 32'(p), 32'(total));
      @(negedge clk);
      cfg_start = 1'b0;
      chk("done_pulse", 32'(done), 32'(1));
      chk("done_valid", 32'(bus.out_valid), 32'(0));
      @(negedge clk);
      chk("done_clear", 32'(done), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("last_count", 32'(lasts), 32'(1));
    end
  endtask

  task automatic run_job(input int m, input bit bp, input bit gaps, input int abort_at,
                         input int poke_at);
    @(negedge clk);
    cfg_rows  = 16'(m);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    fork
      feed(m, gaps);
      consume(m * KN, bp, abort_at, poke_at);
    join
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_a", bus.out_a, 32'(0));
    chk("rst_out_b", bus.out_b, 32'(0));
    chk("rst_flags", 32'({bus.out_last_k, bus.out_last}), 32'(0));
    chk("rst_readies", 32'({bus.a_ready, bus.b_ready}), 32'(0));
    chk("rst_status", 32'({busy, done}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'(0));

    run_job(1, 1'b0, 1'b0, -1, -1);   // basic
    run_job(3, 1'b0, 1'b0, -1, -1);   // multi-row
    run_job(1, 1'b1, 1'b0, -1, -1);   // back-pressure
    run_job(1, 1'b0, 1'b1, -1, -1);   // input bubbles
    run_job(2, 1'b1, 1'b1, -1, -1);   // both combined

    // M = 0 goes straight to FINISH
    @(negedge clk);
    cfg_rows  = 16'd0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("m0_done", 32'(done), 32'(1));
    chk("m0_readies", 32'({bus.a_ready, bus.b_ready, bus.out_valid}), 32'(0));
    @(negedge clk);
    chk("m0_done_clear", 32'(done), 32'(0));
    chk("m0_idle", 32'(busy), 32'(0));
    chk("m0_readies2", 32'({bus.a_ready, bus.b_ready, bus.out_valid}), 32'(0));

    run_job(1, 1'b0, 1'b0, -1, 5);    // cfg_start during STREAM is ignored

    run_job(1, 1'b0, 1'b0, 13, -1);   // reset at pair 13
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_hold_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    run_job(1, 1'b0, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule

// File: doc/matmul_small_k_operand_feeder.md
Name: matmul_small_k_operand_feeder

Overview:
- Upstream operand stage for the small-K matmul datapath; holds a resident K x N tile of B and one K-word row of A.
- Streams (a, b) operand pairs in dot-product order to the matmul core's data_a/data_b/valid_in inputs.
- Marks the end of each K-length dot product and the end of the matrix, so the core can close accumulations.
- Sits between the operand fetch interface and the matmul core.

Parameters:
- DATA_W, 32, operand word width (matches core data_a/data_b).
- K, 4, inner dimension; must be >= 1.
- N, 8, output columns (B tile width); must be >= 1.
- ROWS_W, 16, width of the row-count configuration.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE.
- cfg_rows  in  ROWS_W  number of A rows M, sampled with cfg_start.
- b_valid  in  1  B word valid.
- b_ready  out  1  B word accepted when b_valid && b_ready.
- b_data  in  DATA_W  B word, row-major order: index k*N+n.
- a_valid  in  1  A word valid.
- a_ready  out  1  A word accepted when a_valid && a_ready.
- a_data  in  DATA_W  A word, order k = 0..K-1 within a row.
- out_valid  out  1  operand pair valid; drives core valid_in.
- out_ready  in  1  core accepts a pair when out_valid && out_ready.
- out_a  out  DATA_W  A operand, drives data_a.
- out_b  out  DATA_W  B operand, drives data_b.
- out_last_k  out  1  pair is k = K-1 (end of one dot product).
- out_last  out  1  final pair of the final row/column.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset: state = IDLE; all counters = 0; b_ready, a_ready, out_valid, out_last_k, out_last, busy, done = 0; out_a, out_b = 0. Buffers are not cleared.
- FSM states: IDLE, LOAD_B, LOAD_A, STREAM, FINISH.
- IDLE:
  - On cfg_start, latch cfg_rows as M and clear the row counter.
  - M = 0 -> FINISH.
  - Otherwise -> LOAD_B.
  - cfg_start while busy is ignored.
- LOAD_B:
  - b_ready = 1; each handshake writes b_buf[idx] and increments idx.
  - When word K*N-1 is accepted -> LOAD_A on the next cycle.
- LOAD_A:
  - a_ready = 1; each handshake writes a_buf[k].
  - When word K-1 is accepted -> STREAM, with out_valid = 1 on the next cycle.
- STREAM:
  - Pair order: outer loop n = 0..N-1, inner loop k = 0..K-1.
  - Each pair is out_a = a_buf[k], out_b = b_buf[k*N+n].
  - out_last_k = (k == K-1).
  - out_last = (k == K-1) && (n == N-1) && (row == M-1).
  - A pair advances only on out_valid && out_ready. Outputs are registered and must hold stable while out_valid && !out_ready.
  - Throughput is one pair per cycle under continuous out_ready.
  - When the final pair of a row is accepted:
    - row < M-1: increment row, go to LOAD_A, out_valid = 0 next cycle.
    - row = M-1: go to FINISH.
- FINISH: done = 1 for exactly one cycle, then -> IDLE.
- Mutual exclusion: a_ready and b_ready are never high together, and neither is high during STREAM. A loading does not overlap streaming.
- Latency:
  - First out_valid is asserted 1 cycle after the accepting edge of A word K-1.
  - done is asserted 1 cycle after the handshake of the out_last pair.
- Counters: idx is clog2(K*N) bits, k is clog2(K) bits (minimum 1), n is clog2(N) bits. All wrap to 0 at their terminal count.
- Reset mid-operation: asynchronous return to IDLE. Any in-flight pair is dropped, and out_valid deasserts immediately.
- Stalls: deasserting valid on the input side, or out_ready on the output side, inserts bubbles only. No data is lost or duplicated.

Decomposition:
- Shared package matmul_pkg holds:
  - feeder state enum (IDLE, LOAD_B, LOAD_A, STREAM, FINISH);
  - DATA_W default;
  - localparam functions for counter widths.
- One sub-module: operand_regfile. It is a parameterised DEPTH x DATA_W register file with a synchronous write port and a combinational read port, instantiated twice (b_buf with DEPTH = K*N, a_buf with DEPTH = K).
- FSM, counters and output registers live in the top module.

Test Plan:
1. Basic job: K=4, N=8, M=1; B[i] = i, A = {10, 20, 30, 40}; out_ready held 1 -> 32 pairs. Pair 0 = (10, 0), pair 1 = (20, 8), pair 4 = (10, 1). out_last_k on every 4th pair; out_last only on pair 31 = (40, 31); done 1 cycle later.
2. Multi-row: M=3, new A row per row -> 96 pairs total; a_ready is 0 throughout every STREAM; busy stays 1 until done; out_last asserted exactly once.
3. Back-pressure: toggle out_ready with a random 50% pattern -> out_a/out_b/out_last_k stable while stalled; accepted sequence identical to scenario 1.
4. Input bubbles: b_valid/a_valid with gaps of 0-3 cycles -> same pair sequence; b_ready high for exactly 32 accepted words.
5. Edge configs: M=0 -> done 1 cycle after cfg_start, no b_ready/a_ready/out_valid. cfg_start pulsed during STREAM -> ignored, job completes unchanged.
6. Reset mid-STREAM: drop rst_n at pair 13 -> out_valid, busy and done are 0 immediately. After release, a fresh job with M=1 reproduces the scenario 1 sequence.
